// File: rtl/led_scanout_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// led_scanout_ctrl : walks the framebuffer top-down and shifts it into the LED drivers
// Revision 1.0
// ============================================================================
module led_scanout_ctrl #(
  parameter int c_ledboards = 30,
  parameter int c_channels  = c_ledboards * 32,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_bpc       = 12,
  parameter int c_clkdiv    = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic [c_addr_w-1:0] o_raddr,
  input  logic [c_bpc-1:0]    i_rdata,
  output logic                o_sclk,
  output logic                o_sdata,
  output logic                o_latch,
  output logic                o_blank,
  output logic                o_busy,
  output logic                o_done
);

  localparam int c_bit_w = $clog2(c_bpc + 1);
  localparam int c_ph_w  = $clog2(c_clkdiv + 1);
  localparam logic [c_bit_w-1:0]  c_bit_last = c_bit_w'(c_bpc - 1);
  localparam logic [c_ph_w-1:0]   c_ph_last  = c_ph_w'(c_clkdiv - 1);
  localparam logic [c_addr_w-1:0] c_addr_top = c_addr_w'(c_channels - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                pending, pending_nxt;
  logic [c_bpc-1:0]    shreg, shreg_nxt;
  logic [c_bit_w-1:0]  bit_cnt, bit_cnt_nxt;
  logic [c_ph_w-1:0]   ph_cnt, ph_cnt_nxt;
  logic [c_addr_w-1:0] raddr_nxt;
  logic                sclk_nxt, latch_nxt, blank_nxt, busy_nxt, done_nxt;

  // The serial data pin is the shift register MSB, so it moves only on load or shift.
  assign o_sdata = shreg[c_bpc-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    ph_cnt_nxt  = ph_cnt;
    raddr_nxt   = o_raddr;
    sclk_nxt    = o_sclk;
    latch_nxt   = o_latch;
    blank_nxt   = o_blank;
    busy_nxt    = o_busy;
    done_nxt    = 1'b0;

    if (i_start && o_busy) begin
      pending_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (i_start || pending) begin
          pending_nxt = 1'b0;
          raddr_nxt   = c_addr_top;
          busy_nxt    = 1'b1;
          state_nxt   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_nxt   = i_rdata;
        bit_cnt_nxt = '0;
        ph_cnt_nxt  = '0;
        sclk_nxt    = 1'b0;
        state_nxt   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ph_cnt != c_ph_last) begin
          ph_cnt_nxt = ph_cnt + 1'b1;
        end else begin
          ph_cnt_nxt = '0;
          if (!o_sclk) begin
            sclk_nxt = 1'b1;
          end else begin
            // End of the high phase: the driver has sampled, present the next bit.
            sclk_nxt    = 1'b0;
            shreg_nxt   = {shreg[c_bpc-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 1'b1;
            if (bit_cnt == c_bit_last) begin
              if (o_raddr == '0) begin
                latch_nxt = 1'b1;
                blank_nxt = 1'b1;
                state_nxt = ST_LATCH;
              end else begin
                raddr_nxt = o_raddr - 1'b1;
                state_nxt = ST_FETCH;
              end
            end
          end
        end
      end
      ST_LATCH: begin
        if (ph_cnt != c_ph_last) begin
          ph_cnt_nxt = ph_cnt + 1'b1;
        end else begin
          ph_cnt_nxt = '0;
          latch_nxt  = 1'b0;
          blank_nxt  = 1'b0;
          done_nxt   = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      ph_cnt  <= '0;
      o_raddr <= '0;
      o_sclk  <= 1'b0;
      o_latch <= 1'b0;
      o_blank <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      ph_cnt  <= ph_cnt_nxt;
      o_raddr <= raddr_nxt;
      o_sclk  <= sclk_nxt;
      o_latch <= latch_nxt;
      o_blank <= blank_nxt;
      o_busy  <= busy_nxt;
      o_done  <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_scanout_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_led_scanout_ctrl : directed bench with bit-stream scoreboard, two divider settings
// Revision 1.0
// ============================================================================
module tb_led_scanout_ctrl;

  localparam int CH   = 32;
  localparam int BPC  = 12;
  localparam int CD_A = 1;
  localparam int CD_B = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [4:0]  raddr_a, raddr_b;
  logic [11:0] rdata_a, rdata_b;
  logic        sclk_a, sdata_a, latch_a, blank_a, busy_a, done_a;
  logic        sclk_b, sdata_b, latch_b, blank_b, busy_b, done_b;
  logic [11:0] mem_a [CH];
  logic [11:0] mem_b [CH];

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  led_scanout_ctrl #(.c_ledboards(1), .c_bpc(BPC), .c_clkdiv(CD_A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .o_raddr(raddr_a), .i_rdata(rdata_a),
    .o_sclk(sclk_a), .o_sdata(sdata_a), .o_latch(latch_a), .o_blank(blank_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  led_scanout_ctrl #(.c_ledboards(1), .c_bpc(BPC), .c_clkdiv(CD_B)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .o_raddr(raddr_b), .i_rdata(rdata_b),
    .o_sclk(sclk_b), .o_sdata(sdata_b), .o_latch(latch_b), .o_blank(blank_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  // Registered-read framebuffer models
  always @(posedge clk) begin
    rdata_a <= mem_a[raddr_a];
    rdata_b <= mem_b[raddr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int d);
    for (int ch = CH - 1; ch >= 0; ch--)
      for (int b = BPC - 1; b >= 0; b--)
        exp_q.push_back((d == 0) ? mem_a[ch][b] : mem_b[ch][b]);
  endtask

  task automatic wait_done(input int d, input int budget, output int n);
    n = 1;
    while (((d == 0) ? done_a : done_b) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 32'(n < budget), 1);
  endtask

  // Per-DUT stream monitor, sampled on the falling edge
  logic [1:0] m_sclk, m_sdata, m_latch, m_blank;
  logic [4:0] m_raddr [2];
  logic [1:0] p_sclk, p_sdata, p_latch;
  logic [4:0] p_raddr [2];
  int  run_len[2], latch_len[2], low3[2], low5[2], latch_pulses[2], decs[2];
  bit  seen_latch[2];

  assign m_sclk     = {sclk_b, sclk_a};
  assign m_sdata    = {sdata_b, sdata_a};
  assign m_latch    = {latch_b, latch_a};
  assign m_blank    = {blank_b, blank_a};
  assign m_raddr[0] = raddr_a;
  assign m_raddr[1] = raddr_b;

  always @(negedge clk) begin : mon
    bit e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        run_len[d]    = 0;
        latch_len[d]  = 0;
        seen_latch[d] = 1'b1;
      end else begin
        if (m_sclk[d] && !p_sclk[d]) begin
          chk("bit_available", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("serial_bit", m_sdata[d], e);
          end
          if (run_len[d] == 3) low3[d]++;
          else if (run_len[d] == 5) low5[d]++;
          run_len[d] = 1;
        end else if (!m_sclk[d] && p_sclk[d]) begin
          chk("sclk_high_len", run_len[d], (d == 0) ? CD_A : CD_B);
          run_len[d] = 1;
        end else begin
          run_len[d]++;
        end
        if (m_sclk[d] && p_sclk[d]) chk("sdata_stable_high", m_sdata[d], p_sdata[d]);
        chk("blank_tracks_latch", m_blank[d], m_latch[d]);
        if (m_latch[d]) begin
          chk("sclk_low_in_latch", m_sclk[d], 0);
          if (!p_latch[d]) begin
            latch_pulses[d]++;
            chk("latch_after_last_bit", exp_q.size(), 0);
            seen_latch[d] = 1'b1;
          end
          latch_len[d]++;
        end else if (p_latch[d]) begin
          chk("latch_len", latch_len[d], (d == 0) ? CD_A : CD_B);
          latch_len[d] = 0;
        end
        if (m_raddr[d] != p_raddr[d]) begin
          if (p_raddr[d] == 5'd0) begin
            chk("raddr_no_wrap", seen_latch[d], 1);
            chk("raddr_start_top", m_raddr[d], 31);
            seen_latch[d] = 1'b0;
          end else begin
            chk("raddr_step", m_raddr[d], p_raddr[d] - 5'd1);
            decs[d]++;
          end
        end
      end
      p_sclk[d]  = m_sclk[d];
      p_sdata[d] = m_sdata[d];
      p_latch[d] = m_latch[d];
      p_raddr[d] = m_raddr[d];
    end
  end

  int   n, lp, dc, l3, l5;
  logic flag;

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < CH; i++) begin
      mem_a[i] = (i % 4 == 0) ? 12'hFFF : 12'h000;
      mem_b[i] = 12'(i * 157 + 41);
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs_a", {raddr_a, sclk_a, sdata_a, latch_a, blank_a, busy_a, done_a}, 0);
    chk("reset_outputs_b", {raddr_b, sclk_b, sdata_b, latch_b, blank_b, busy_b, done_b}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy_a", busy_a, 0);
    chk("idle_busy_b", busy_b, 0);

    // Frame timing and data content, divider 1
    push_frame(0);
    lp = latch_pulses[0];
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("busy_after_start_a", busy_a, 1);
    wait_done(0, 3000, n);
    chk("frame_len_a", n, 834);
    chk("frame_bits_consumed_a", exp_q.size(), 0);
    chk("latch_pulses_a", latch_pulses[0] - lp, 1);
    @(negedge clk);
    chk("done_one_cycle_a", done_a, 0);
    chk("busy_drop_a", busy_a, 0);

    // Request merging: three requests during one frame yield exactly one more
    for (int i = 0; i < CH; i++) mem_a[i] = 12'(i * 37 + 5);
    push_frame(0);
    lp = latch_pulses[0];
    dc = decs[0];
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (100 + 50 * k) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    wait_done(0, 3000, n);
    push_frame(0);
    @(negedge clk);
    chk("merge_idle_busy", busy_a, 0);
    chk("merge_done_pulse", done_a, 0);
    @(negedge clk);
    chk("merge_second_fetch_busy", busy_a, 1);
    chk("merge_second_fetch_addr", raddr_a, 31);
    wait_done(0, 3000, n);
    chk("merge_frame2_len", n, 834);
    flag = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      flag = flag | busy_a | done_a;
    end
    chk("merge_no_third_frame", flag, 0);
    chk("merge_bits_consumed", exp_q.size(), 0);
    chk("merge_latch_pulses", latch_pulses[0] - lp, 2);
    chk("merge_addr_decrements", decs[0] - dc, 62);

    // Asynchronous reset in the middle of channel 17, with a request pending
    push_frame(0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!(raddr_a == 5'd17 && sclk_a == 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_ch17_shift", 32'(n < 2000), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs_a", {raddr_a, sclk_a, sdata_a, latch_a, blank_a, busy_a, done_a}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (200) begin
      @(negedge clk);
      flag = flag | busy_a | done_a | sclk_a | latch_a;
    end
    chk("stay_idle_after_reset", flag, 0);
    chk("raddr_idle_after_reset", raddr_a, 0);

    // Divider 3: phase lengths and frame length
    push_frame(1);
    lp = latch_pulses[1];
    l3 = low3[1];
    l5 = low5[1];
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("busy_after_start_b", busy_b, 1);
    wait_done(1, 4000, n);
    chk("frame_len_b", n, 2372);
    chk("low_phase_3_count_b", low3[1] - l3, 352);
    chk("low_gap_5_count_b", low5[1] - l5, 31);
    chk("frame_bits_consumed_b", exp_q.size(), 0);
    chk("latch_pulses_b", latch_pulses[1] - lp, 1);
    @(negedge clk);
    chk("busy_drop_b", busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_scanout_ctrl.md
# led_scanout_ctrl

Scanout sequencer for the LED framebuffer. On a frame request it walks the framebuffer read port from the last channel down to channel 0 and shifts each c_bpc-bit word MSB-first into the daisy-chained LED driver boards. It then pulses latch/blank to transfer the frame into the drivers. It is the sole owner of the framebuffer read port and sits between the framebuffer and the LED driver pins.

## Interface
- c_ledboards, 30, number of daisy-chained LED driver boards
- c_channels, c_ledboards*32, total channels in the chain
- c_addr_w, $clog2(c_channels), framebuffer address width
- c_bpc, 12, bits per channel
- c_clkdiv, 1, i_clk cycles per o_sclk phase (≥1); one bit takes 2*c_clkdiv cycles

- i_clk  in  1  single clock; all logic on posedge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  frame request; single-cycle pulse or level
- o_raddr  out  c_addr_w  framebuffer read address
- i_rdata  in  c_bpc  framebuffer read data, valid one cycle after o_raddr (registered read)
- o_sclk  out  1  driver shift clock
- o_sdata  out  1  driver serial data, changes only while o_sclk is low
- o_latch  out  1  driver latch
- o_blank  out  1  driver blank, high during latch
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, FETCH, LOAD, SHIFT, LATCH, DONE.
- IDLE: o_busy=0. If i_start or pending is high, clear pending, set o_raddr<=c_channels-1 and o_busy<=1, and go to FETCH.
- FETCH: one cycle while the framebuffer registers the read. Go to LOAD.
- LOAD: capture i_rdata into the c_bpc-bit shift register, reset the bit and phase counters, and go to SHIFT.
- SHIFT: o_sdata = shift register MSB.
  - o_sclk is low for c_clkdiv cycles, then high for c_clkdiv cycles.
  - On the cycle the high phase ends, shift left by one and increment the bit counter.
  - After c_bpc bits:
    - if o_raddr==0, go to LATCH;
    - else decrement o_raddr and go to FETCH.
- LATCH: o_latch=1 and o_blank=1 for c_clkdiv cycles, o_sclk=0. Go to DONE.
- DONE: o_done=1 for one cycle, then go to IDLE. o_busy drops on entry to IDLE.
- i_start while o_busy=1 sets a single pending flag. Further requests are merged into it. A pending request starts the next frame straight from IDLE, with no extra idle cycle beyond the one IDLE cycle.
- o_raddr never wraps below 0 and never exceeds c_channels-1. Counter widths: bit counter $clog2(c_bpc+1), phase counter $clog2(c_clkdiv+1).
- Framebuffer writes during a frame are not arbitrated here. Each word is taken as read at its FETCH.

## Timing
- Reset values (asynchronous, immediate, also mid-frame):
  - state=IDLE, pending=0
  - o_raddr=0, o_sclk=0, o_sdata=0, o_latch=0, o_blank=0, o_busy=0, o_done=0
  - shift register and counters cleared.
- Release from reset: the first start is accepted at the first posedge where i_rst_n=1 and i_start=1.
- Per channel: 2 + 2*c_bpc*c_clkdiv cycles (FETCH, LOAD, SHIFT).
- Start edge to o_done high: 1 + c_channels*(2 + 2*c_bpc*c_clkdiv) + c_clkdiv cycles.
- Back-to-back frames (pending set): o_done to the next FETCH takes 2 cycles (DONE then IDLE).
- o_sdata is stable for the whole o_sclk high phase. It changes only at the start of a low phase or on entry to SHIFT.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Frame timing (c_ledboards=1, c_clkdiv=1; 32 channels, 26 cycles/channel): start pulse at cycle 0 -> o_busy high from cycle 1, o_done single pulse exactly 834 cycles after the start edge, o_busy low the cycle after o_done.
- Data order and content: memory model preloaded with 12'hFFF at every 4th address and 0 elsewhere, serial stream captured on o_sclk rising edges -> 384 bits in order ch31, ch30, …, ch0. Every group of 12 is 0x000 except ch28, ch24, …, ch0, which are 0xFFF. Exactly one o_latch/o_blank pulse, 1 cycle wide, after the last bit.
- Clock divider: c_clkdiv=3 -> o_sclk low 3 / high 3 cycles, o_sdata constant through each high phase, frame-to-done length 1+32*74+3=2372 cycles.
- Request merging: 3 start pulses during a busy frame -> exactly one further frame starts, FETCH 2 cycles after the first o_done, and no third frame follows.
- Reset mid-frame: i_rst_n low during SHIFT of ch17 -> all outputs at reset values in the same cycle, pending cleared. After release with no i_start, the block stays IDLE with o_busy=0.
- Address bounds: o_raddr monitored across 2 frames -> always within 0..31, strictly decreasing by 1 per channel, never wraps to 31 before LATCH.
